rpi_link_tx: RTL and testbench
==============================

# rpi_link_tx

Downstream stage of the camera capture path: drains the on-chip pixel FIFO and delivers each frame to the Raspberry Pi over the 8-bit parallel `valid`/`ack` link. Each frame is framed with a 3-byte header and an optional checksum trailer. Every byte goes through a fully interlocked four-phase handshake, with the asynchronous `ack` synchronized internally. Sits between the internal `ov7670_fifo` read port and the JXADC/JC pins.

## Interface
- `FRAME_BYTES`, 38400: payload bytes per frame (QQVGA RGB565); legal range 1..2^20-1.
- `SYNC_STAGES`, 2: flip-flop stages on `ack`; legal range 2..4.
- `clk` in 1: 100 MHz system clock.
- `reset_n` in 1: asynchronous, active-low reset; one clock domain.
- `frame_start` in 1: one-cycle pulse from the capture FSM when a new frame read begins.
- `fifo_dout` in 8: FIFO read data; valid one cycle after `fifo_rd_en`.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_en` out 1: FIFO read strobe, one cycle per payload byte.
- `ack` in 1: RPi acknowledge; asynchronous.
- `valid` out 1: byte on `d_out` is ready (registered).
- `d_out` out 8: link data (registered).
- `frame_cnt` out 8: count of completed frames; wraps 255→0.
- `busy` out 1: a frame is in progress (state ≠ IDLE).
- `overrun` out 1: sticky; set when `frame_start` arrives while busy.

## Operation
- Byte order per frame: 0xA5, 0x5A, `frame_cnt` (value at frame start), then `FRAME_BYTES` payload bytes, then the trailer if compiled in.
- FSM states:
  - IDLE → HDR on `frame_start`.
  - HDR drives header bytes 0..2 through the handshake. No FIFO read.
  - FETCH: waits while `fifo_empty`=1. When not empty, pulses `fifo_rd_en` for one cycle → LOAD.
  - LOAD: on the next edge, `d_out` ← `fifo_dout` and `valid` ← 1 → WAIT_ACK.
  - WAIT_ACK: when `ack_s`=1, `valid` ← 0 → WAIT_REL.
  - WAIT_REL: when `ack_s`=0, advance to the next byte. Go to FETCH while payload remains; otherwise go to TRL, or to DONE when the trailer is not compiled in.
  - TRL: sends the checksum bytes through the same handshake.
  - DONE: `frame_cnt` ← `frame_cnt`+1 → IDLE.
- A byte is never presented while `ack_s`=1. If `ack` is high when a byte is ready, `valid` is held low until `ack_s` reads 0.
- `d_out` holds its last value when `valid`=0.
- Payload counter is 20 bits. It resets to 0 in HDR and compares against `FRAME_BYTES`-1 for the last byte.
- `frame_start` while busy is ignored and sets `overrun`. A frame is never restarted mid-transfer.
- `ack` toggling while `valid`=0 outside WAIT_REL is ignored.

## Timing
- Reset values: `valid`=0, `d_out`=0x00, `fifo_rd_en`=0, `frame_cnt`=0, `busy`=0, `overrun`=0, state=IDLE, checksum=0.
- `reset_n` low mid-frame: all outputs go to reset values immediately (asynchronously). The partial frame is discarded and bytes already read from the FIFO are not replayed.
- Payload latency: `fifo_rd_en` high in cycle N; `valid`=1 and `d_out`=data visible from cycle N+2.
- Header bytes: `valid` rises 1 cycle after entering HDR, or after WAIT_REL exits for subsequent header bytes.
- `ack` rising → `valid` falls after `SYNC_STAGES`+1 cycles.
- `ack` falling → next `fifo_rd_en` (or next header/trailer `valid`) after `SYNC_STAGES`+1 cycles.
- `frame_start` accepted in IDLE → `busy`=1 the next cycle.

## Configuration
- `RPI_LINK_CSUM_EN` defined:
  - A 16-bit checksum accumulates the modulo-2^16 sum of payload bytes only, not the header.
  - The checksum clears in HDR.
  - Sent as 2 trailer bytes after the payload, high byte first.
  - Frame length is `FRAME_BYTES`+5.
- Not defined:
  - No accumulator and no TRL state.
  - Frame length is `FRAME_BYTES`+3.

## Test plan
- Reset, `FRAME_BYTES`=4, FIFO holding 0x01,0x02,0x03,0x04, one `frame_start`, auto-ack responder (ack follows `valid` after 5 cycles) → link carries A5,5A,00,01,02,03,04. With the macro defined, 00,0A is appended. Afterwards `frame_cnt`=1 and `busy`=0.
- FIFO empty for 50 cycles mid-payload → `fifo_rd_en` stays 0 and `valid` stays 0; transfer resumes on the first byte written, with no duplicate or lost bytes.
- `ack` held high before `frame_start` → `valid` stays 0 until `ack` drops, then 0xA5 is presented `SYNC_STAGES`+1 cycles later.
- `frame_start` pulsed during payload byte 2 → `overrun`=1 and stays 1; the current frame completes normally with a single header.
- `reset_n` asserted low while in WAIT_ACK on payload byte 3 → `valid`=0, `d_out`=0x00 and `frame_cnt`=0 immediately. A new `frame_start` then sends header byte 00.
- 256 back-to-back frames with `FRAME_BYTES`=1 → the header count byte runs 00..FF, then `frame_cnt` wraps to 0x00.

Source files
------------

// File: rtl/rpi_link_tx.sv
// Frame transmitter: FIFO payload to the RPi over a four-phase valid/ack byte link.
// Define RPI_LINK_CSUM_EN to append a 16-bit payload checksum trailer (high byte first).
module rpi_link_tx #(
  parameter int unsigned FRAME_BYTES = 38400,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic       ack,
  output logic       valid,
  output logic [7:0] d_out,
  output logic [7:0] frame_cnt,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE, HDR, FETCH, LOAD, WAIT_ACK, WAIT_REL, DONE
`ifdef RPI_LINK_CSUM_EN
    , TRL
`endif
  } state_t;

  typedef enum logic [1:0] {SEG_HDR, SEG_PAY, SEG_TRL} seg_t;

  localparam logic [19:0] LAST_IDX = 20'(FRAME_BYTES - 1);

  state_t                 state;
  seg_t                   seg;
  logic [1:0]             hdr_idx;
  logic [19:0]            pay_cnt;
  logic [1:0]             ld_stage;
  logic [7:0]             pay_buf;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
`ifdef RPI_LINK_CSUM_EN
  logic [15:0]            csum;
  logic                   trl_idx;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ack_sync <= '0;
    else          ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
  end
  assign ack_s = ack_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      seg        <= SEG_HDR;
      hdr_idx    <= '0;
      pay_cnt    <= '0;
      ld_stage   <= '0;
      pay_buf    <= '0;
      fifo_rd_en <= 1'b0;
      valid      <= 1'b0;
      d_out      <= '0;
      frame_cnt  <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
`ifdef RPI_LINK_CSUM_EN
      csum       <= '0;
      trl_idx    <= 1'b0;
`endif
    end else begin
      fifo_rd_en <= 1'b0;
      if (frame_start && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (frame_start) begin
          state   <= HDR;
          seg     <= SEG_HDR;
          hdr_idx <= '0;
          busy    <= 1'b1;
        end
        HDR: begin
          pay_cnt <= '0;
`ifdef RPI_LINK_CSUM_EN
          csum    <= '0;
`endif
          if (!ack_s) begin
            valid <= 1'b1;
            case (hdr_idx)
              2'd0:    d_out <= 8'hA5;
              2'd1:    d_out <= 8'h5A;
              default: d_out <= frame_cnt;
            endcase
            state <= WAIT_ACK;
          end
        end
        FETCH: if (!fifo_empty) begin
          fifo_rd_en <= 1'b1;
          ld_stage   <= '0;
          state      <= LOAD;
        end
        // Stage 0 covers the FIFO read latency; stage 1 captures fifo_dout
        // into pay_buf so a late ack release cannot lose the byte.
        LOAD: begin
          if (ld_stage == 2'd0) begin
            ld_stage <= 2'd1;
          end else if (ld_stage == 2'd1) begin
            pay_buf <= fifo_dout;
`ifdef RPI_LINK_CSUM_EN
            csum    <= csum + {8'h00, fifo_dout};
`endif
            if (!ack_s) begin
              d_out <= fifo_dout;
              valid <= 1'b1;
              state <= WAIT_ACK;
            end else begin
              ld_stage <= 2'd2;
            end
          end else if (!ack_s) begin
            d_out <= pay_buf;
            valid <= 1'b1;
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: if (ack_s) begin
          valid <= 1'b0;
          state <= WAIT_REL;
        end
        WAIT_REL: if (!ack_s) begin
          case (seg)
            SEG_HDR: begin
              if (hdr_idx == 2'd2) begin
                seg   <= SEG_PAY;
                state <= FETCH;
              end else begin
                hdr_idx <= hdr_idx + 2'd1;
                state   <= HDR;
              end
            end
            SEG_PAY: begin
              if (pay_cnt == LAST_IDX) begin
`ifdef RPI_LINK_CSUM_EN
                seg     <= SEG_TRL;
                trl_idx <= 1'b0;
                state   <= TRL;
`else
                state   <= DONE;
`endif
              end else begin
                pay_cnt <= pay_cnt + 20'd1;
                state   <= FETCH;
              end
            end
            default: begin
`ifdef RPI_LINK_CSUM_EN
              if (trl_idx) begin
                state <= DONE;
              end else begin
                trl_idx <= 1'b1;
                state   <= TRL;
              end
`else
              state <= DONE;
`endif
            end
          endcase
        end
`ifdef RPI_LINK_CSUM_EN
        TRL: if (!ack_s) begin
          d_out <= trl_idx ? csum[7:0] : csum[15:8];
          valid <= 1'b1;
          state <= WAIT_ACK;
        end
`endif
        DONE: begin
          frame_cnt <= frame_cnt + 8'd1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpi_link_tx.sv
// Scoreboard bench for rpi_link_tx: frame-level reference model, FIFO model, auto-ack responder.
module tb_rpi_link_tx;
  localparam int unsigned FB = 4;
  localparam int unsigned SS = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd_en;
  logic       ack = 1'b0;
  logic       valid;
  logic [7:0] d_out;
  logic [7:0] frame_cnt;
  logic       busy;
  logic       overrun;

  int          errors = 0;
  int          checks = 0;
  byte unsigned exp_q[$];
  byte unsigned fifo_q[$];
  byte unsigned pend_q[$];
  int unsigned mon_bytes = 0;
  int unsigned model_cnt = 0;
  int          ack_mode = 0;
  int unsigned ack_dly = 5;
  logic [7:0]  hist = '0;

  rpi_link_tx #(.FRAME_BYTES(FB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .ack(ack), .valid(valid), .d_out(d_out), .frame_cnt(frame_cnt),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO with one-cycle read latency
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Responder: ack follows valid after ack_dly cycles; mode 1 forces high, 2 forces low
  initial begin
    forever begin
      @(negedge clk);
      hist = {hist[6:0], valid};
      case (ack_mode)
        1:       ack = 1'b1;
        2:       begin ack = 1'b0; hist = '0; end
        default: ack = hist[ack_dly-1];
      endcase
    end
  end

  // Monitor: every new byte presented on the link is popped from the scoreboard
  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (valid === 1'b1 && !prev_valid) begin
        mon_bytes++;
        check("ack_low_at_present", 32'(ack), 32'(0));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", d_out);
        end else begin
          check("link_byte", 32'(d_out), 32'(exp_q.pop_front()));
        end
      end
      prev_valid = (valid === 1'b1);
    end
  end

  task automatic feed_n(input int unsigned n);
    for (int unsigned i = 0; i < n && pend_q.size() > 0; i++) fifo_q.push_back(pend_q.pop_front());
  endtask

  task automatic start_frame(input bit directed, input bit feed);
    int unsigned sum;
    byte unsigned b;
    sum = 0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'(model_cnt));
    for (int unsigned i = 0; i < FB; i++) begin
      b = directed ? 8'(i + 1) : 8'($urandom_range(0, 255));
      sum += b;
      exp_q.push_back(b);
      pend_q.push_back(b);
    end
`ifdef RPI_LINK_CSUM_EN
    exp_q.push_back(8'((sum >> 8) % 256));
    exp_q.push_back(8'(sum % 256));
`endif
    model_cnt = (model_cnt + 1) % 256;
    if (feed) feed_n(FB);
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("frame_timeout", 32'(n < 5000), 32'(1));
    check("frame_cnt", 32'(frame_cnt), 32'(model_cnt));
    check("bytes_outstanding", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic wait_bytes(input int unsigned target);
    int n;
    n = 0;
    while (mon_bytes < target && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("byte_wait_timeout", 32'(n < 2000), 32'(1));
  endtask

  task automatic wait_ack(input logic lvl);
    int n;
    n = 0;
    while (ack !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ack_wait_timeout", 32'(n < 200), 32'(1));
  endtask

  task automatic flush_model();
    exp_q.delete();
    fifo_q.delete();
    pend_q.delete();
    model_cnt = 0;
  endtask

  initial begin
    int unsigned base;
    int rd_cnt, v_cnt, n;

    #1;
    check("rst_valid", 32'(valid), 32'(0));
    check("rst_d_out", 32'(d_out), 32'(0));
    check("rst_rd_en", 32'(fifo_rd_en), 32'(0));
    check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_overrun", 32'(overrun), 32'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Directed frame: payload 01..04
    start_frame(1'b1, 1'b1);
    check("busy_after_start", 32'(busy), 32'(1));
    wait_idle();
    check("busy_done", 32'(busy), 32'(0));

    for (int i = 0; i < 4; i++) begin
      ack_dly = $urandom_range(1, 6);
      start_frame(1'b0, 1'b1);
      wait_idle();
    end
    ack_dly = 5;

    // FIFO runs dry after payload byte 2 for 50 cycles
    base = mon_bytes;
    start_frame(1'b0, 1'b0);
    feed_n(2);
    wait_bytes(base + 5);
    wait_ack(1'b1);
    wait_ack(1'b0);
    repeat (6) @(negedge clk);
    rd_cnt = 0;
    v_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) rd_cnt++;
      if (valid === 1'b1) v_cnt++;
    end
    check("stall_rd_en", 32'(rd_cnt), 32'(0));
    check("stall_valid", 32'(v_cnt), 32'(0));
    feed_n(FB);
    wait_idle();

    // ack held high before frame_start
    ack_mode = 1;
    repeat (5) @(negedge clk);
    start_frame(1'b0, 1'b1);
    v_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid === 1'b1) v_cnt++;
    end
    check("ack_high_valid_low", 32'(v_cnt), 32'(0));
    @(posedge clk);
    #2 ack_mode = 0;
    @(negedge clk);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (valid === 1'b1) break;
    end
    check("ack_release_latency", 32'(n), 32'(SS + 1));
    wait_idle();

    // frame_start during payload byte 2
    check("overrun_clear", 32'(overrun), 32'(0));
    base = mon_bytes;
    start_frame(1'b0, 1'b1);
    wait_bytes(base + 5);
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    wait_idle();
    check("overrun_set", 32'(overrun), 32'(1));
    repeat (20) @(negedge clk);
    start_frame(1'b0, 1'b1);
    wait_idle();
    check("overrun_sticky", 32'(overrun), 32'(1));

    // Reset while waiting for ack on payload byte 3
    ack_dly = 8;
    base = mon_bytes;
    start_frame(1'b0, 1'b1);
    wait_bytes(base + 6);
    check("pre_reset_valid", 32'(valid), 32'(1));
    ack_mode = 2;
    reset_n = 1'b0;
    #1;
    check("async_valid", 32'(valid), 32'(0));
    check("async_d_out", 32'(d_out), 32'(0));
    check("async_frame_cnt", 32'(frame_cnt), 32'(0));
    check("async_busy", 32'(busy), 32'(0));
    check("async_overrun", 32'(overrun), 32'(0));
    flush_model();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    ack_mode = 0;
    ack_dly = 5;
    start_frame(1'b0, 1'b1);
    wait_idle();

    // 256 back-to-back frames: header count runs through 00..FF and wraps
    @(negedge clk) reset_n = 1'b0;
    flush_model();
    @(negedge clk) reset_n = 1'b1;
    ack_dly = 1;
    for (int i = 0; i < 256; i++) begin
      start_frame(1'b0, 1'b1);
      wait_idle();
    end
    check("frame_cnt_wrap", 32'(frame_cnt), 32'(0));

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
